// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, baud-rate table and divisor helper.
// The RX path is expected to reuse the same table and helper.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   // br 8..15 alias the fastest rate so the CSR reset value 4'hf lands on 115200
   localparam int unsigned BAUD_HZ [0:15] = '{
      1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200,
      115200, 115200, 115200, 115200, 115200, 115200, 115200, 115200
   };

   function automatic logic [31:0] div_for(input int unsigned clk_hz, input logic [3:0] br);
      return 32'(clk_hz / BAUD_HZ[br]);
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter; bit_end marks the last cycle of each bit period.
// Reloads itself on bit_end so consecutive bits need no extra load pulse.
module uart_baud_cnt #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic             bit_end
);

   logic [DIV_W-1:0] cnt;

   assign bit_end = run && !load && (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load || bit_end) begin
         cnt <= div - DIV_W'(1);
      end else if (!run) begin
         cnt <= '0;
      end else begin
         cnt <= cnt - DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: one STRTX pulse sends one 8N1 frame (8E1 when UART_TX_PARITY_EN is defined).
// Divisor and data are latched at frame start so CSR writes mid-frame cannot disturb the line.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned DIV_W  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       strtx,
   input  logic [3:0] br,
   input  logic [7:0] txdata,
   output logic       uart_tx,
   output logic       tbusy,
   output logic       tx_done
);

   logic [DIV_W-1:0] div_lut [16];

   for (genvar g = 0; g < 16; g++) begin : g_div
      localparam logic [31:0] DIV_FULL = div_for(CLK_HZ, 4'(g));
      if (DIV_FULL < 32'd2 || (DIV_FULL >> DIV_W) != 32'd0) begin : g_bad
         $error("uart_tx_ctrl: baud divisor out of range for CLK_HZ/DIV_W");
      end
      assign div_lut[g] = DIV_FULL[DIV_W-1:0];
   end

   tx_state_t        state;
   tx_state_t        state_nx;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt_div;
   logic [7:0]       shreg;
   logic [7:0]       shreg_nx;
   logic [2:0]       idx;
   logic             start_go;
   logic             bit_end;
   logic             tx_nx;
   logic             par_bit;

   assign start_go = (state == IDLE) && en && strtx;
   assign cnt_div  = start_go ? div_lut[br] : div_q;

   uart_baud_cnt #(.DIV_W(DIV_W)) u_baud_cnt (
      .clk     (clk),
      .rst     (rst),
      .run     (state != IDLE),
      .load    (start_go),
      .div     (cnt_div),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   if (en && strtx) state_nx = START;
         START:  if (bit_end) state_nx = DATA;
         DATA: begin
            if (bit_end && idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_nx = PARITY;
`else
               state_nx = STOP;
`endif
            end
         end
         PARITY: if (bit_end) state_nx = STOP;
         STOP:   if (bit_end) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      // losing enable abandons the frame from any active state
      if (state != IDLE && !en) state_nx = IDLE;
   end

   always_comb begin
      case (state_nx)
         START:   tx_nx = 1'b0;
         DATA:    tx_nx = shreg_nx[0];
         PARITY:  tx_nx = par_bit;
         default: tx_nx = 1'b1;
      endcase
      tbusy   = (state != IDLE);
      tx_done = (state == STOP) && bit_end && en;
   end

   always_comb begin
      shreg_nx = shreg;
      if (start_go) begin
         shreg_nx = txdata;
      end else if (state == DATA && bit_end) begin
         shreg_nx = shreg >> 1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q   <= '0;
         shreg   <= '0;
         idx     <= '0;
         uart_tx <= 1'b1;
      end else begin
         uart_tx <= tx_nx;
         shreg   <= shreg_nx;
         if (start_go) begin
            div_q <= div_lut[br];
            idx   <= '0;
         end else if (state == DATA && bit_end) begin
            idx <= idx + 3'd1;
         end
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         par_bit <= 1'b0;
      end else if (start_go) begin
         par_bit <= ^txdata;
      end
   end
`else
   assign par_bit = 1'b1;
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-level reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic including aborts and resets.
module tb_uart_tx_ctrl;

   localparam int unsigned CLK_HZ = 1_152_000;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       strtx;
   logic [3:0] br;
   logic [7:0] txdata;
   logic       uart_tx;
   logic       tbusy;
   logic       tx_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   uart_tx_ctrl #(.CLK_HZ(CLK_HZ), .DIV_W(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .strtx   (strtx),
      .br      (br),
      .txdata  (txdata),
      .uart_tx (uart_tx),
      .tbusy   (tbusy),
      .tx_done (tx_done)
   );

   always #5 clk = ~clk;

   // frame model: m_n is the cycle in which the start request was sampled
   int unsigned baud_hz [16] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200,
                                 115200, 115200, 115200, 115200, 115200, 115200, 115200, 115200};
   bit       m_act = 1'b0;
   int       m_n = 0;
   int       m_div = 1;
   bit [7:0] m_data = 8'h00;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         m_act = 1'b0;
      end else if (m_act) begin
         if (!en || (cyc - m_n) == NB * m_div + 1) m_act = 1'b0;
      end else if (en && strtx) begin
         m_act  = 1'b1;
         m_n    = cyc - 1;
         m_div  = int'(CLK_HZ / baud_hz[br]);
         m_data = txdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic compare_loop();
      int  o;
      int  b;
      bit  e_tx;
      bit  e_busy;
      bit  e_done;
      forever begin
         @(negedge clk);
         if (cyc >= 1) begin
            e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            if (m_act) begin
               o = cyc - m_n;
               b = (o - 1) / m_div;
               e_busy = 1'b1;
               if (b == 0) e_tx = 1'b0;
               else if (b <= 8) e_tx = m_data[b-1];
               else if (NB == 11 && b == 9) e_tx = ^m_data;
               else e_tx = 1'b1;
               e_done = (o == NB * m_div) && en;
            end
            chk("model_uart_tx", 32'(uart_tx), 32'(e_tx));
            chk("model_tbusy", 32'(tbusy), 32'(e_busy));
            chk("model_tx_done", 32'(tx_done), 32'(e_done));
         end
      end
   endtask

   // wait until the negedge in the middle of cycle k (the cycle after edge k)
   task automatic at_cyc(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
   endtask

   int n;
   int n2;

   initial begin
      rst = 1'b1; en = 1'b0; strtx = 1'b0; br = 4'hf; txdata = 8'h00;
      fork
         compare_loop();
      join_none
      at_cyc(3);
      chk("reset_uart_tx", 32'(uart_tx), 32'd1);
      chk("reset_tbusy", 32'(tbusy), 32'd0);
      chk("reset_tx_done", 32'(tx_done), 32'd0);
      rst = 1'b0;
      at_cyc(5);

      // basic A5 frame, busy strtx with 3C at N+40, back-to-back restart
      n = cyc;
      en = 1'b1; br = 4'd7; txdata = 8'hA5; strtx = 1'b1;
      at_cyc(n + 1);
      strtx = 1'b0; txdata = 8'h5A;
      chk("s1_start_bit", 32'(uart_tx), 32'd0);
      chk("s1_tbusy", 32'(tbusy), 32'd1);
      at_cyc(n + 10);  chk("s1_start_last", 32'(uart_tx), 32'd0);
      at_cyc(n + 11);  chk("s1_d0", 32'(uart_tx), 32'd1);
      at_cyc(n + 21);  chk("s1_d1", 32'(uart_tx), 32'd0);
      at_cyc(n + 31);  chk("s1_d2", 32'(uart_tx), 32'd1);
      at_cyc(n + 39);  strtx = 1'b1; txdata = 8'h3C;
      at_cyc(n + 40);  strtx = 1'b0;
      at_cyc(n + 41);  chk("s2_d3", 32'(uart_tx), 32'd0);
      at_cyc(n + 51);  chk("s2_d4", 32'(uart_tx), 32'd0);
      at_cyc(n + 61);  chk("s2_d5", 32'(uart_tx), 32'd1);
      at_cyc(n + 71);  chk("s2_d6", 32'(uart_tx), 32'd0);
      at_cyc(n + 81);  chk("s2_d7", 32'(uart_tx), 32'd1);
      at_cyc(n + 91);  chk("s1_bit9", 32'(uart_tx), (NB == 11) ? 32'd0 : 32'd1);
      at_cyc(n + NB * 10 - 1); chk("s1_no_early_done", 32'(tx_done), 32'd0);
      at_cyc(n + NB * 10);     chk("s1_tx_done", 32'(tx_done), 32'd1);
      chk("s1_stop", 32'(uart_tx), 32'd1);
      at_cyc(n + NB * 10 + 1);
      chk("s1_tbusy_low", 32'(tbusy), 32'd0);
      chk("s2_no_second_done", 32'(tx_done), 32'd0);
      n2 = cyc;
      strtx = 1'b1; txdata = 8'hC3;
      at_cyc(n2 + 1);
      strtx = 1'b0;
      chk("s3_b2b_start", 32'(uart_tx), 32'd0);
      chk("s3_b2b_busy", 32'(tbusy), 32'd1);
      at_cyc(n2 + NB * 10 + 1);
      chk("s3_end", 32'(tbusy), 32'd0);

      // abort by dropping en, then a clean frame
      at_cyc(cyc + 3);
      n = cyc;
      strtx = 1'b1; txdata = 8'h96;
      at_cyc(n + 1);  strtx = 1'b0;
      at_cyc(n + 35); en = 1'b0;
      at_cyc(n + 36);
      chk("s4_abort_tx", 32'(uart_tx), 32'd1);
      chk("s4_abort_busy", 32'(tbusy), 32'd0);
      chk("s4_abort_done", 32'(tx_done), 32'd0);
      en = 1'b1; strtx = 1'b1; txdata = 8'h69; n2 = cyc;
      at_cyc(n2 + 1); strtx = 1'b0;
      at_cyc(n2 + 11); chk("s4_clean_d0", 32'(uart_tx), 32'd1);
      at_cyc(n2 + NB * 10); chk("s4_clean_done", 32'(tx_done), 32'd1);

      // br=0 gives 960-cycle bits; changing br mid-frame must not matter
      at_cyc(cyc + 2);
      n = cyc;
      br = 4'd0; txdata = 8'h01; strtx = 1'b1;
      at_cyc(n + 1);   strtx = 1'b0;
      at_cyc(n + 500); br = 4'd7;
      at_cyc(n + 960); chk("s5_start_960", 32'(uart_tx), 32'd0);
      at_cyc(n + 961); chk("s5_d0", 32'(uart_tx), 32'd1);
      at_cyc(n + 1921); chk("s5_d1", 32'(uart_tx), 32'd0);
      at_cyc(n + NB * 960 + 1); chk("s5_end", 32'(tbusy), 32'd0);

      // synchronous reset mid-frame
      at_cyc(cyc + 2);
      n = cyc;
      txdata = 8'h07; strtx = 1'b1;
      at_cyc(n + 1);  strtx = 1'b0;
      at_cyc(n + 55); chk("s6_busy_pre_rst", 32'(tbusy), 32'd1); rst = 1'b1;
      at_cyc(n + 56);
      chk("s6_rst_tx", 32'(uart_tx), 32'd1);
      chk("s6_rst_busy", 32'(tbusy), 32'd0);
      chk("s6_rst_done", 32'(tx_done), 32'd0);
      rst = 1'b0;

      // full 07 frame: bit 7 is 0, bit 9 is parity 1 or stop 1
      at_cyc(cyc + 2);
      n = cyc;
      txdata = 8'h07; strtx = 1'b1;
      at_cyc(n + 1);  strtx = 1'b0;
      at_cyc(n + 81); chk("s6_d7", 32'(uart_tx), 32'd0);
      at_cyc(n + 91); chk("s6_bit9", 32'(uart_tx), 32'd1);
      at_cyc(n + NB * 10); chk("s6_done", 32'(tx_done), 32'd1);

      // randomized traffic
      for (int i = 0; i < 20000; i++) begin
         at_cyc(cyc + 1);
         strtx  = ($urandom % 16) == 0;
         en     = ($urandom % 400) != 0;
         rst    = ($urandom % 3000) == 0;
         txdata = 8'($urandom);
         if (($urandom % 50) == 0) br = 4'($urandom_range(3, 15));
      end
      at_cyc(cyc + 2);
      rst = 1'b0; strtx = 1'b0;
      at_cyc(cyc + NB * 120 + 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
